beep_timer_multi: RTL

//  Multi-channel programmable timer/tone generator; successor to the single-channel beep timer.
//  N_CH independent channels, each periodic or one-shot, with pause/resume, shadowed period

---
 rtl/beep_timer_pkg.sv | 19 +
 rtl/beep_timer_ch.sv | 147 ++++++++++++++
 rtl/beep_timer_multi.sv | 62 ++++++
 3 files changed

// File: rtl/beep_timer_pkg.sv
// Shared definitions for the multi-channel beep timer: channel modes,
// channel state encoding and a helper for the channel-select width.
package beep_timer_pkg;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } ch_state_t;

   // A single-channel build still needs a 1-bit select port.
   function automatic int ch_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/beep_timer_ch.sv
// One timer channel: IDLE/RUN/DONE control, tick counter, shadowed period
// reload and the tone output.
module beep_timer_ch
   import beep_timer_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_tick,
   input  logic             i_ena,
   input  logic             i_we,
   input  logic [CNT_W-1:0] i_period,
   input  logic             i_mode,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_flag,
   output logic             o_busy,
   output logic             o_beep
);

   ch_state_t        r_state;
   ch_state_t        w_state_next;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_period;
   logic             r_mode;
   logic [CNT_W-1:0] r_shadow_period;
   logic             r_shadow_mode;
   logic             r_shadow_valid;
   logic             r_flag;
   logic             r_beep;

   logic             w_abort;
   logic [CNT_W-1:0] w_period_eff;
   logic             w_mode_eff;
   logic             w_start;
   logic             w_expire;

   // A write arriving with the start edge takes effect for that start.
   assign w_abort      = i_we && (i_period == '0);
   assign w_period_eff = i_we ? i_period : r_period;
   assign w_mode_eff   = i_we ? i_mode   : r_mode;
   assign w_start      = (r_state == ST_IDLE) && i_ena && !w_abort && (w_period_eff != '0);
   assign w_expire     = (r_state == ST_RUN) && i_ena && i_tick && (r_cnt == r_period - 1'b1);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_start) begin
               w_state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            if (w_abort) begin
               w_state_next = ST_IDLE;
            end else if (w_expire && (r_mode == MODE_ONESHOT)) begin
               w_state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            if (w_abort || !i_ena) begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      o_busy = (r_state == ST_RUN);
      o_cnt  = r_cnt;
      o_flag = r_flag;
      o_beep = r_beep;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt           <= '0;
         r_period        <= '0;
         r_mode          <= MODE_ONESHOT;
         r_shadow_period <= '0;
         r_shadow_mode   <= MODE_ONESHOT;
         r_shadow_valid  <= 1'b0;
         r_flag          <= 1'b0;
         r_beep          <= 1'b0;
      end else begin
         r_flag <= 1'b0;
         if (w_abort) begin
            r_period       <= '0;
            r_mode         <= i_mode;
            r_shadow_valid <= 1'b0;
            r_cnt          <= '0;
            r_beep         <= 1'b0;
         end else if (r_state == ST_RUN) begin
            if (i_we) begin
               r_shadow_period <= i_period;
               r_shadow_mode   <= i_mode;
               r_shadow_valid  <= 1'b1;
            end
            if (w_expire) begin
               r_cnt  <= '0;
               r_flag <= 1'b1;
               if (r_mode == MODE_ONESHOT) begin
                  r_beep <= 1'b0;
               end else if (r_shadow_valid && (r_shadow_mode == MODE_ONESHOT)) begin
                  r_beep <= 1'b1;
               end else begin
                  r_beep <= ~r_beep;
               end
               // A write on the expiry edge stays pending for the next expiry.
               if (r_shadow_valid) begin
                  r_period <= r_shadow_period;
                  r_mode   <= r_shadow_mode;
                  if (!i_we) begin
                     r_shadow_valid <= 1'b0;
                  end
               end
            end else if (i_ena && i_tick) begin
               r_cnt <= r_cnt + 1'b1;
            end
         end else begin
            if (i_we) begin
               r_period       <= i_period;
               r_mode         <= i_mode;
               r_shadow_valid <= 1'b0;
            end else if (r_shadow_valid) begin
               r_period       <= r_shadow_period;
               r_mode         <= r_shadow_mode;
               r_shadow_valid <= 1'b0;
            end
            if (w_start) begin
               r_cnt  <= '0;
               r_beep <= (w_mode_eff == MODE_ONESHOT);
            end
         end
      end
   end

endmodule

// File: rtl/beep_timer_multi.sv
// Multi-channel programmable timer / tone generator: shared prescaler,
// config write decode and N_CH independent channels.
module beep_timer_multi
   import beep_timer_pkg::*;
#(
   parameter  int N_CH  = 4,
   parameter  int CNT_W = 32,
   parameter  int PRESC = 1,
   localparam int CH_W  = ch_idx_w(N_CH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_we,
   input  logic [CH_W-1:0]       cfg_ch,
   input  logic [CNT_W-1:0]      cfg_period,
   input  logic                  cfg_mode,
   input  logic [N_CH-1:0]       ena,
   output logic [N_CH*CNT_W-1:0] cnt_now,
   output logic [N_CH-1:0]       flag,
   output logic [N_CH-1:0]       busy,
   output logic [N_CH-1:0]       beep
);

   logic [15:0]     r_presc;
   logic            w_tick;
   logic [N_CH-1:0] w_we;

   // With PRESC=1 the compare is always true, giving a tick every clock.
   assign w_tick = (r_presc == 16'(PRESC - 1));

   always_ff @(posedge clk) begin
      if (rst || w_tick) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + 16'd1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_ch
         assign w_we[gi] = cfg_we && (cfg_ch == CH_W'(gi));

         beep_timer_ch #(
            .CNT_W (CNT_W)
         ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .i_tick   (w_tick),
            .i_ena    (ena[gi]),
            .i_we     (w_we[gi]),
            .i_period (cfg_period),
            .i_mode   (cfg_mode),
            .o_cnt    (cnt_now[gi*CNT_W +: CNT_W]),
            .o_flag   (flag[gi]),
            .o_busy   (busy[gi]),
            .o_beep   (beep[gi])
         );
      end
   endgenerate

endmodule
